io_bus_bridge: RTL and testbench

- Avalon-MM slave on the HPS lightweight bridge window 0xFF21_0000–0xFF21_FFFF.
- Converts each read/write into a timed 16-bit IO bus cycle: setup, strobe, hold.
- Drives Address, IOSelect_H and ByteSelect_L into the serial IO decoder, and data/RW strobes to the 16550 UART chips (Bluetooth, WiFi, USB).
- Holds the CPU with waitrequest until the IO cycle completes.

---
 rtl/io_bus_pkg.sv | 28 ++
 rtl/io_bus_timer.sv | 27 ++
 rtl/io_bus_bridge.sv | 238 +++++++++++++++++++++++
 tb/tb_io_bus_bridge.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared definitions for the IO bus bridge: FSM states, default timing,
// IO window base and the read-timeout pattern.
package io_bus_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSetup  = 3'd1,
    StStrobe = 3'd2,
    StHold   = 3'd3,
    StDone   = 3'd4
  } io_state_e;

  localparam int unsigned DefSetupCycles  = 1;
  localparam int unsigned DefStrobeCycles = 4;
  localparam int unsigned DefHoldCycles   = 1;
  localparam int unsigned DefMaxWait      = 255;

  // Upper half of the HPS lightweight bridge address this slave decodes.
  localparam logic [15:0] IoWindowBase = 16'hFF21;
  // Read data returned when a waited strobe times out.
  localparam logic [15:0] ReadTimeout  = 16'hDEAD;

  // Expand a 2-bit byte enable into a 16-bit data mask.
  function automatic logic [15:0] byte_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/io_bus_timer.sv
// Loadable 4-bit down-counter with zero flag; times the SETUP, STROBE and
// HOLD phases of an IO bus cycle.
module io_bus_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count_q;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec && (count_q != 4'd0)) begin
      count_q <= count_q - 4'd1;
    end
  end

  assign zero = (count_q == 4'd0);

endmodule

// File: rtl/io_bus_bridge.sv
// Avalon-MM slave to timed 16-bit IO bus bridge. Each Avalon access becomes
// a setup / strobe / hold IO cycle; waitrequest holds the CPU until done.
// Optional build macro IO_BRIDGE_WAIT_EN adds the IO_Wait_H strobe
// extension input with a MAX_WAIT cycle timeout.
module io_bus_bridge
  import io_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = DefSetupCycles,
  parameter int unsigned STROBE_CYCLES = DefStrobeCycles,
  parameter int unsigned HOLD_CYCLES   = DefHoldCycles
`ifdef IO_BRIDGE_WAIT_EN
  ,
  parameter int unsigned MAX_WAIT      = DefMaxWait
`endif
) (
  input  logic        Clock,
  input  logic        Reset_H,
  input  logic [15:0] avs_address,
  input  logic [1:0]  avs_byteenable,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [15:0] avs_writedata,
  output logic [15:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic [15:0] Address,
  output logic        IOSelect_H,
  output logic        ByteSelect_L,
  output logic        LowerByteSelect_L,
  output logic        RW_L,
  output logic [15:0] IO_DataOut,
  output logic        IO_DataOE,
`ifdef IO_BRIDGE_WAIT_EN
  input  logic        IO_Wait_H,
`endif
  input  logic [15:0] IO_DataIn
);

  localparam logic [3:0] SetupLoad  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] StrobeLoad = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HoldLoad   = 4'(HOLD_CYCLES - 1);

  io_state_e   state_q, state_d;

  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic [1:0]  be_q;
  logic        write_q;
  logic        done_q;

  logic        io_sel_q;
  logic        ub_sel_q;
  logic        lb_sel_q;
  logic        rw_q;
  logic        oe_q;

  logic        accept;
  logic        sample;
  logic        timeout;
  logic        tmr_load;
  logic        tmr_dec;
  logic        tmr_zero;
  logic [3:0]  tmr_value;

  logic        bus_active_d;
  logic [1:0]  be_n;
  logic        write_n;

`ifdef IO_BRIDGE_WAIT_EN
  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);
  logic [7:0] ext_q, ext_d;
`endif

  io_bus_timer u_timer (
    .clk        (Clock),
    .rst        (Reset_H),
    .load       (tmr_load),
    .load_value (tmr_value),
    .dec        (tmr_dec),
    .zero       (tmr_zero)
  );

  // State register (and strobe-extension count when enabled).
  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
`ifdef IO_BRIDGE_WAIT_EN
      ext_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == StDone);
`ifdef IO_BRIDGE_WAIT_EN
      ext_q   <= ext_d;
`endif
    end
  end

  // Next-state logic and phase timer control.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    sample    = 1'b0;
    timeout   = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_value = 4'd0;
`ifdef IO_BRIDGE_WAIT_EN
    ext_d     = 8'd0;
`endif
    unique case (state_q)
      StIdle: begin
        if (avs_read || avs_write) begin
          accept = 1'b1;
          if (avs_byteenable == 2'b00) begin
            // Nothing to transfer: skip the bus cycle entirely.
            state_d = StDone;
          end else begin
            state_d   = StSetup;
            tmr_load  = 1'b1;
            tmr_value = SetupLoad;
          end
        end
      end
      StSetup: begin
        if (tmr_zero) begin
          state_d   = StStrobe;
          tmr_load  = 1'b1;
          tmr_value = StrobeLoad;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      StStrobe: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
`ifdef IO_BRIDGE_WAIT_EN
          if (IO_Wait_H && (ext_q != MaxWait)) begin
            // Device still busy: stretch the strobe by one more cycle.
            ext_d = ext_q + 8'd1;
          end else begin
            if (IO_Wait_H) begin
              timeout = 1'b1;
            end else begin
              sample = 1'b1;
            end
            state_d   = StHold;
            tmr_load  = 1'b1;
            tmr_value = HoldLoad;
          end
`else
          sample    = 1'b1;
          state_d   = StHold;
          tmr_load  = 1'b1;
          tmr_value = HoldLoad;
`endif
        end
      end
      StHold: begin
        if (tmr_zero) begin
          state_d = StDone;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Values the output registers will see after this edge.
  always_comb begin
    be_n         = accept ? avs_byteenable : be_q;
    write_n      = accept ? avs_write : write_q;
    bus_active_d = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
  end

  // Latch the request in IDLE; capture read data at the end of the strobe.
  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      rdata_q <= 16'd0;
      be_q    <= 2'b00;
      write_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= avs_address;
        be_q    <= avs_byteenable;
        write_q <= avs_write;
        if (avs_write) begin
          wdata_q <= avs_writedata;
        end
      end
      if (accept && !avs_write) begin
        rdata_q <= 16'd0;
      end else if (sample && !write_q) begin
        rdata_q <= IO_DataIn & byte_mask(be_q);
      end else if (timeout && !write_q) begin
        rdata_q <= ReadTimeout;
      end
    end
  end

  // Registered bus controls, decoded from the next state so they are glitch free.
  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      io_sel_q <= 1'b0;
      ub_sel_q <= 1'b1;
      lb_sel_q <= 1'b1;
      rw_q     <= 1'b1;
      oe_q     <= 1'b0;
    end else begin
      io_sel_q <= (state_d == StStrobe);
      ub_sel_q <= ~(bus_active_d & be_n[1]);
      lb_sel_q <= ~(bus_active_d & be_n[0]);
      rw_q     <= ~(bus_active_d & write_n);
      oe_q     <= bus_active_d & write_n;
    end
  end

  assign avs_waitrequest   = (avs_read | avs_write) & ~done_q;
  assign avs_readdata      = rdata_q;
  assign Address           = addr_q;
  assign IOSelect_H        = io_sel_q;
  assign ByteSelect_L      = ub_sel_q;
  assign LowerByteSelect_L = lb_sel_q;
  assign RW_L              = rw_q;
  assign IO_DataOut        = wdata_q;
  assign IO_DataOE         = oe_q;

endmodule

// File: tb/tb_io_bus_bridge.sv
// Scoreboard bench for io_bus_bridge: requests push expected responses,
// a negedge monitor measures each IO cycle and checks on completion.
module tb_io_bus_bridge;

  logic        Clock = 1'b0;
  logic        Reset_H = 1'b1;
  logic [15:0] avs_address = 16'd0;
  logic [1:0]  avs_byteenable = 2'b00;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [15:0] avs_writedata = 16'd0;
  logic [15:0] avs_readdata;
  logic        avs_waitrequest;
  logic [15:0] Address;
  logic        IOSelect_H;
  logic        ByteSelect_L;
  logic        LowerByteSelect_L;
  logic        RW_L;
  logic [15:0] IO_DataOut;
  logic        IO_DataOE;
  logic [15:0] IO_DataIn = 16'd0;
`ifdef IO_BRIDGE_WAIT_EN
  logic        IO_Wait_H = 1'b0;
`endif

  always #5 Clock = ~Clock;

`ifdef IO_BRIDGE_WAIT_EN
  io_bus_bridge #(.MAX_WAIT(3)) dut (
`else
  io_bus_bridge dut (
`endif
    .Clock             (Clock),
    .Reset_H           (Reset_H),
    .avs_address       (avs_address),
    .avs_byteenable    (avs_byteenable),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_waitrequest   (avs_waitrequest),
    .Address           (Address),
    .IOSelect_H        (IOSelect_H),
    .ByteSelect_L      (ByteSelect_L),
    .LowerByteSelect_L (LowerByteSelect_L),
    .RW_L              (RW_L),
    .IO_DataOut        (IO_DataOut),
    .IO_DataOE         (IO_DataOE),
`ifdef IO_BRIDGE_WAIT_EN
    .IO_Wait_H         (IO_Wait_H),
`endif
    .IO_DataIn         (IO_DataIn)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  typedef struct {
    logic        is_write;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] data;     // bus write data, or expected readdata
    int          waits;    // cycles with waitrequest high
    int          strobes;  // cycles with IOSelect_H high
  } exp_t;

  exp_t exp_q[$];

  // Monitor state
  int          wait_cnt, strobe_cnt, ub_cnt, lb_cnt, oe_cnt, rwl_cnt, gap;
  logic        prev_sel, seen_pulse, addr_moved;
  logic [15:0] addr_at_strb, data_at_strb, prev_addr;

  function automatic void clear_txn();
    wait_cnt = 0; strobe_cnt = 0; ub_cnt = 0; lb_cnt = 0;
    oe_cnt = 0; rwl_cnt = 0; addr_moved = 1'b0;
    addr_at_strb = 16'd0; data_at_strb = 16'd0;
  endfunction

  initial begin
    exp_t e;
    int   active;
    clear_txn();
    prev_sel = 1'b0; seen_pulse = 1'b0; gap = 0; prev_addr = 16'd0;
    forever begin
      @(negedge Clock);
      if (Reset_H) begin
        clear_txn();
        prev_sel = 1'b0; seen_pulse = 1'b0; gap = 0;
      end else begin
        if (IOSelect_H) begin
          if (!prev_sel && seen_pulse) chk("strobe_gap_ge3", 32'(gap >= 3), 32'd1);
          if (prev_sel && (Address !== prev_addr)) addr_moved = 1'b1;
          strobe_cnt++;
          addr_at_strb = Address;
          data_at_strb = IO_DataOut;
          seen_pulse = 1'b1;
          gap = 0;
        end else begin
          gap++;
        end
        prev_sel = IOSelect_H;
        prev_addr = Address;
        if (!ByteSelect_L) ub_cnt++;
        if (!LowerByteSelect_L) lb_cnt++;
        if (IO_DataOE) oe_cnt++;
        if (!RW_L) rwl_cnt++;
        if (avs_read || avs_write) begin
          if (avs_waitrequest) begin
            wait_cnt++;
          end else if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(exp_q.size()), 32'd1);
            clear_txn();
          end else begin
            e = exp_q.pop_front();
            active = (e.strobes == 0) ? 0 : e.strobes + 2;
            chk("wait_cycles", 32'(wait_cnt), 32'(e.waits));
            chk("strobe_cycles", 32'(strobe_cnt), 32'(e.strobes));
            chk("upper_sel_cycles", 32'(ub_cnt), 32'(e.be[1] ? active : 0));
            chk("lower_sel_cycles", 32'(lb_cnt), 32'(e.be[0] ? active : 0));
            chk("rw_low_cycles", 32'(rwl_cnt), 32'(e.is_write ? active : 0));
            chk("oe_cycles", 32'(oe_cnt), 32'(e.is_write ? active : 0));
            chk("addr_stable_in_strobe", 32'(addr_moved), 32'd0);
            if (active != 0) chk("strobe_address", 32'(addr_at_strb), 32'(e.addr));
            if (e.is_write) chk("strobe_wdata", 32'(data_at_strb), 32'(e.data));
            else chk("readdata", 32'(avs_readdata), 32'(e.data));
            clear_txn();
          end
        end
      end
    end
  end

  // Issue one request (caller sits just after a posedge) and wait for it.
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [1:0] be,
                        input logic [15:0] data, input int waits, input int strobes);
    exp_t e;
    logic fin;
    e.is_write = wr; e.be = be; e.addr = addr; e.data = data;
    e.waits = waits; e.strobes = strobes;
    exp_q.push_back(e);
    avs_address = addr;
    avs_byteenable = be;
    avs_writedata = wr ? data : 16'h0000;
    avs_write = wr;
    avs_read = !wr;
    fin = 1'b0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge Clock);
      if (!avs_waitrequest) fin = 1'b1;
      else if (i == 2) begin
        // Scramble the held inputs; the bridge must use its latched copy.
        avs_address = ~avs_address;
        avs_writedata = ~avs_writedata;
      end
    end
    if (!fin) begin
      chk("req_timeout", 32'd0, 32'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_back());
    end
    @(posedge Clock);
    #1;
    avs_read = 1'b0;
    avs_write = 1'b0;
  endtask

  initial begin
    logic seen;
    repeat (2) @(negedge Clock);
    chk("rst_address", 32'(Address), 32'd0);
    chk("rst_ioselect", 32'(IOSelect_H), 32'd0);
    chk("rst_bytesel", 32'(ByteSelect_L), 32'd1);
    chk("rst_lowersel", 32'(LowerByteSelect_L), 32'd1);
    chk("rst_rw", 32'(RW_L), 32'd1);
    chk("rst_dataout", 32'(IO_DataOut), 32'd0);
    chk("rst_oe", 32'(IO_DataOE), 32'd0);
    chk("rst_readdata", 32'(avs_readdata), 32'd0);
    chk("rst_waitrequest", 32'(avs_waitrequest), 32'd0);
    @(posedge Clock); #1;
    Reset_H = 1'b0;
    @(posedge Clock); #1;

    // Upper-byte write: 6 select cycles, 4 strobe cycles, 7 wait cycles.
    do_req(1'b1, 16'h1000, 2'b10, 16'h5A00, 7, 4);
    repeat (2) @(posedge Clock); #1;
    // Upper-byte read of 16'hA55A returns 16'hA500.
    IO_DataIn = 16'hA55A;
    do_req(1'b0, 16'h1010, 2'b10, 16'hA500, 7, 4);
    // Empty byteenable: completes on the second cycle, readdata cleared.
    do_req(1'b0, 16'h1012, 2'b00, 16'h0000, 1, 0);
    // Lower-byte read masks off the upper byte.
    IO_DataIn = 16'h1234;
    do_req(1'b0, 16'h1002, 2'b01, 16'h0034, 7, 4);
    // Full-word write.
    do_req(1'b1, 16'h1004, 2'b11, 16'hBEEF, 7, 4);
    repeat (2) @(posedge Clock); #1;

    // Reset during STROBE: strobes must drop without waiting for a clock.
    avs_address = 16'h1040; avs_byteenable = 2'b11; avs_read = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clock);
      if (IOSelect_H) seen = 1'b1;
    end
    chk("strobe_reached", 32'(seen), 32'd1);
    #2 Reset_H = 1'b1;
    #1;
    chk("async_rst_ioselect", 32'(IOSelect_H), 32'd0);
    chk("async_rst_bytesel", 32'(ByteSelect_L), 32'd1);
    chk("async_rst_lowersel", 32'(LowerByteSelect_L), 32'd1);
    avs_read = 1'b0;
    @(negedge Clock);
    @(posedge Clock); #1;
    Reset_H = 1'b0;
    @(posedge Clock); #1;
    IO_DataIn = 16'h5A5A;
    do_req(1'b0, 16'h1042, 2'b11, 16'h5A5A, 7, 4);
    repeat (2) @(posedge Clock); #1;

    // Back-to-back writes; the monitor checks the strobe gap and address.
    do_req(1'b1, 16'h1020, 2'b11, 16'h1111, 7, 4);
    do_req(1'b1, 16'h1000, 2'b01, 16'h2222, 7, 4);

`ifdef IO_BRIDGE_WAIT_EN
    // Wait held high: 4 + 3 strobe cycles then timeout pattern.
    repeat (2) @(posedge Clock); #1;
    IO_Wait_H = 1'b1;
    do_req(1'b0, 16'h1030, 2'b11, 16'hDEAD, 10, 7);
    IO_Wait_H = 1'b0;
    IO_DataIn = 16'hC3C3;
    do_req(1'b0, 16'h1032, 2'b11, 16'hC3C3, 7, 4);
`endif

    repeat (4) @(posedge Clock);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
